// File: rtl/ap_ctrl_pipeline_sequencer.sv
// rtl/ap_ctrl_pipeline_sequencer.sv - host-side ap_ctrl start/ready relay sequencer
// Turns the host's level handshake into single-cycle relay tokens, one in flight at a time.
module ap_ctrl_pipeline_sequencer #(
  parameter int HEAD_LEVEL   = 0,
  parameter int BODY_LEVEL   = 8,
  parameter int TAIL_LEVEL   = 0,
  parameter int GRACE_PERIOD = (HEAD_LEVEL + BODY_LEVEL + TAIL_LEVEL) * 2,
  parameter int TIMEOUT      = 1024,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             host_ap_start,
  output logic             host_ap_ready,
  output logic             pp_start_valid,
  input  logic             pp_ready_valid,
  input  logic             err_clr,
  output logic             busy,
  output logic             timeout_err,
  output logic             stray_err,
  output logic [CNT_W-1:0] txn_count
);

  typedef enum logic [2:0] {
    S_WARMUP = 3'd0,
    S_IDLE   = 3'd1,
    S_ISSUE  = 3'd2,
    S_WAIT   = 3'd3,
    S_ACK    = 3'd4
  } state_t;

  localparam int GW = (GRACE_PERIOD > 1) ? $clog2(GRACE_PERIOD) : 1;
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [GW-1:0] GRACE_LAST = GW'((GRACE_PERIOD > 0) ? GRACE_PERIOD - 1 : 0);
  localparam logic [TW-1:0] TMO_LAST   = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [TW-1:0] TMO_MAX    = TW'(TIMEOUT);
  localparam state_t RESET_STATE = (GRACE_PERIOD == 0) ? S_IDLE : S_WARMUP;

  state_t           state_q, state_d;
  logic [GW-1:0]    grace_q, grace_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic [CNT_W-1:0] txn_q, txn_d;
  logic             start_q, start_d;
  logic             ack_q, ack_d;
  logic             busy_q, busy_d;
  logic             tmo_err_q, tmo_err_d;
  logic             stray_err_q, stray_err_d;
  logic             tmo_evt, stray_evt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RESET_STATE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_WARMUP: if (grace_q == GRACE_LAST) state_d = S_IDLE;
      S_IDLE:   if (host_ap_start) state_d = S_ISSUE;
      S_ISSUE:  state_d = S_WAIT;
      S_WAIT:   if (pp_ready_valid) state_d = S_ACK;
      S_ACK:    state_d = S_IDLE;
      default:  state_d = RESET_STATE;
    endcase
  end

  // Outputs are registered from the next state so every token lines up with its state.
  always_comb begin
    grace_d = grace_q;
    if (state_q == S_WARMUP) grace_d = grace_q + GW'(1);

    tmo_d = tmo_q;
    if (state_q == S_ISSUE) begin
      tmo_d = '0;
    end else if (state_q == S_WAIT && tmo_q != TMO_MAX) begin
      tmo_d = tmo_q + TW'(1);
    end

    tmo_evt   = (TIMEOUT != 0) && (state_q == S_WAIT) && (tmo_q == TMO_LAST);
    stray_evt = pp_ready_valid &&
                (state_q == S_IDLE || state_q == S_ISSUE || state_q == S_ACK);

    tmo_err_d   = tmo_evt   | (tmo_err_q   & ~err_clr);
    stray_err_d = stray_evt | (stray_err_q & ~err_clr);

    txn_d   = (state_d == S_ACK) ? txn_q + CNT_W'(1) : txn_q;
    start_d = (state_d == S_ISSUE);
    ack_d   = (state_d == S_ACK);
    busy_d  = (state_d == S_ISSUE) || (state_d == S_WAIT) || (state_d == S_ACK);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grace_q     <= '0;
      tmo_q       <= '0;
      txn_q       <= '0;
      start_q     <= 1'b0;
      ack_q       <= 1'b0;
      busy_q      <= 1'b0;
      tmo_err_q   <= 1'b0;
      stray_err_q <= 1'b0;
    end else begin
      grace_q     <= grace_d;
      tmo_q       <= tmo_d;
      txn_q       <= txn_d;
      start_q     <= start_d;
      ack_q       <= ack_d;
      busy_q      <= busy_d;
      tmo_err_q   <= tmo_err_d;
      stray_err_q <= stray_err_d;
    end
  end

  assign pp_start_valid = start_q;
  assign host_ap_ready  = ack_q;
  assign busy           = busy_q;
  assign timeout_err    = tmo_err_q;
  assign stray_err      = stray_err_q;
  assign txn_count      = txn_q;

endmodule

// File: tb/tb_ap_ctrl_pipeline_sequencer.sv
// tb/tb_ap_ctrl_pipeline_sequencer.sv - directed bench for ap_ctrl_pipeline_sequencer
// Edge k counts posedges after reset release; outputs are sampled 1ns after each edge.
module tb_ap_ctrl_pipeline_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        host_ap_start;
  logic        host_ap_ready;
  logic        pp_start_valid;
  logic        pp_ready_valid;
  logic        err_clr;
  logic        busy;
  logic        timeout_err;
  logic        stray_err;
  logic [31:0] txn_count;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  ap_ctrl_pipeline_sequencer #(
    .TIMEOUT(20)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .host_ap_start (host_ap_start),
    .host_ap_ready (host_ap_ready),
    .pp_start_valid(pp_start_valid),
    .pp_ready_valid(pp_ready_valid),
    .err_clr       (err_clr),
    .busy          (busy),
    .timeout_err   (timeout_err),
    .stray_err     (stray_err),
    .txn_count     (txn_count)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, 32'(host_ap_ready), 0);
    check({tag, "_start"}, 32'(pp_start_valid), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_tmo"}, 32'(timeout_err), 0);
    check({tag, "_stray"}, 32'(stray_err), 0);
    check({tag, "_txn"}, txn_count, 0);
  endtask

  int start_edges[$];
  int ready_edges[$];
  int txn_at_ready[$];
  int pend;
  int early_starts;
  int exp_start[3] = '{17, 36, 55};
  int exp_ready[3] = '{34, 53, 72};
  int n_starts;
  int n_acks;
  int first_start;

  initial begin
    reset          = 1'b0;
    host_ap_start  = 1'b1;
    pp_ready_valid = 1'b0;
    err_clr        = 1'b0;

    // Reset state, with start already asserted
    tick();
    tick();
    check_all_zero("reset");

    // Grace, round trip and back-to-back with a 16-cycle loopback
    reset = 1'b1;
    pend = -1;
    early_starts = 0;
    for (int k = 1; k <= 80; k++) begin
      tick();
      if (pp_start_valid) begin
        start_edges.push_back(k);
        pend = k + 16;
        if (k <= 16) early_starts++;
      end
      if (host_ap_ready) begin
        ready_edges.push_back(k);
        txn_at_ready.push_back(int'(txn_count));
        if (ready_edges.size() == 3) host_ap_start = 1'b0;
      end
      if (k == 6) check("warmup_token_no_stray", 32'(stray_err), 0);
      if (k == 17) check("first_issue_busy", 32'(busy), 1);
      pp_ready_valid = (k == 4) || (k == pend);
    end
    pp_ready_valid = 1'b0;
    check("grace_no_early_issue", early_starts, 0);
    check("start_pulses", start_edges.size(), 3);
    check("ready_pulses", ready_edges.size(), 3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("start_edge%0d", i), (i < start_edges.size()) ? start_edges[i] : -1, exp_start[i]);
      check($sformatf("ready_edge%0d", i), (i < ready_edges.size()) ? ready_edges[i] : -1, exp_ready[i]);
      check($sformatf("txn_at_ready%0d", i), (i < txn_at_ready.size()) ? txn_at_ready[i] : -1, i + 1);
    end
    check("b2b_txn", txn_count, 3);
    check("b2b_idle", 32'(busy), 0);
    check("b2b_tmo", 32'(timeout_err), 0);
    check("b2b_stray", 32'(stray_err), 0);

    // Stray token in IDLE, then err_clr priority
    pp_ready_valid = 1'b1;
    tick();
    pp_ready_valid = 1'b0;
    check("stray_set", 32'(stray_err), 1);
    check("stray_no_ack", 32'(host_ap_ready), 0);
    check("stray_not_busy", 32'(busy), 0);
    tick();
    check("stray_txn", txn_count, 3);
    check("stray_sticky", 32'(stray_err), 1);
    err_clr = 1'b1;
    pp_ready_valid = 1'b1;
    tick();
    err_clr = 1'b0;
    pp_ready_valid = 1'b0;
    check("stray_set_wins", 32'(stray_err), 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("stray_cleared", 32'(stray_err), 0);
    check("clr_keeps_txn", txn_count, 3);

    // Timeout after 20 WAIT cycles, late token still completes
    host_ap_start = 1'b1;
    tick();
    check("tmo_issue", 32'(pp_start_valid), 1);
    for (int i = 1; i <= 31; i++) begin
      tick();
      if (i == 1) check("tmo_single_pulse", 32'(pp_start_valid), 0);
      if (i == 20) check("tmo_not_yet", 32'(timeout_err), 0);
      if (i == 21) check("tmo_set", 32'(timeout_err), 1);
      if (i == 30) pp_ready_valid = 1'b1;
      if (i == 31) begin
        pp_ready_valid = 1'b0;
        host_ap_start = 1'b0;
        check("tmo_late_ack", 32'(host_ap_ready), 1);
        check("tmo_txn", txn_count, 4);
      end
    end
    tick();
    check("tmo_ack_one_cycle", 32'(host_ap_ready), 0);
    check("tmo_sticky", 32'(timeout_err), 1);
    check("tmo_no_stray", 32'(stray_err), 0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("tmo_cleared", 32'(timeout_err), 0);

    // Asynchronous reset mid-WAIT, then grace restarts and a late token is dropped
    host_ap_start = 1'b1;
    tick();
    tick();
    tick();
    check("wait_busy", 32'(busy), 1);
    #2;
    reset = 1'b0;
    #1;
    check_all_zero("async");
    tick();
    reset = 1'b1;
    n_starts = 0;
    n_acks = 0;
    first_start = -1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (pp_start_valid) begin
        n_starts++;
        if (first_start < 0) first_start = k;
      end
      if (host_ap_ready) n_acks++;
      pp_ready_valid = (k == 3);
    end
    pp_ready_valid = 1'b0;
    check("rst_first_issue", first_start, 17);
    check("rst_issue_count", n_starts, 1);
    check("rst_no_ack", n_acks, 0);
    check("rst_no_stray", 32'(stray_err), 0);
    check("rst_txn", txn_count, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ap_ctrl_pipeline_sequencer.md
Name: ap_ctrl_pipeline_sequencer

Overview:
- Host-side controller for a pipelined ap_ctrl start/ready relay: HEAD/BODY/TAIL register stages carrying a start token to the kernel and a ready token back.
- Converts the host's level-sensitive ap_start/ap_ready handshake into single-cycle tokens on the relay.
- Allows at most one token in flight; holds off issue during a post-reset grace period while the relay flushes.
- Provides timeout and stray-token error detection and a completed-transaction counter.

Parameters:
- HEAD_LEVEL, 0, head register stages in the relay (informational; used only in GRACE_PERIOD)
- BODY_LEVEL, 8, body register stages in the relay
- TAIL_LEVEL, 0, tail register stages in the relay
- GRACE_PERIOD, (HEAD_LEVEL+BODY_LEVEL+TAIL_LEVEL)*2, cycles after reset release before the first issue; 0 means no warmup
- TIMEOUT, 1024, WAIT cycles before timeout_err is set; 0 disables the timeout
- CNT_W, 32, txn_count width

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- host_ap_start  in  1  host start level; held high until host_ap_ready
- host_ap_ready  out  1  one-cycle acknowledge to host
- pp_start_valid  out  1  one-cycle start token into relay head
- pp_ready_valid  in  1  one-cycle ready token from relay tail
- err_clr  in  1  synchronous clear of sticky errors
- busy  out  1  high in ISSUE, WAIT and ACK
- timeout_err  out  1  sticky
- stray_err  out  1  sticky
- txn_count  out  CNT_W  completed transactions

Behaviour:
- Reset (reset=0, asynchronous) forces:
  - state WARMUP; all outputs 0
  - grace, timeout and txn_count counters cleared
  - if GRACE_PERIOD=0, reset state is IDLE instead of WARMUP
- All outputs are registered.
- WARMUP:
  - grace counter increments each cycle; at GRACE_PERIOD-1 go to IDLE
  - pp_ready_valid is discarded, with no error flag
  - host_ap_start is ignored
- IDLE:
  - host_ap_start=1 → ISSUE
  - pp_ready_valid=1 → stray_err=1 next cycle, token dropped, stay IDLE
- ISSUE (1 cycle):
  - pp_start_valid=1; timeout counter cleared; → WAIT
  - pp_ready_valid=1 here counts as stray (sets stray_err)
- WAIT:
  - pp_start_valid=0; timeout counter increments, saturating
  - pp_ready_valid=1 → ACK
  - timeout counter reaches TIMEOUT (TIMEOUT≠0) → timeout_err=1; stay in WAIT; a late token still completes normally
  - host_ap_start dropping in WAIT is tolerated; the transaction still completes and acks
- ACK (1 cycle):
  - host_ap_ready=1; txn_count += 1 (wraps at 2^CNT_W); → IDLE
  - pp_ready_valid=1 here → stray_err
- Latency:
  - host_ap_start high in IDLE at edge N → pp_start_valid high during cycle N+1
  - return token at edge M → host_ap_ready high during cycle M+1
  - Minimum back-to-back issue spacing: ACK → IDLE → ISSUE, so a new start is issued 2 cycles after the ack cycle when host_ap_start stays high.
- err_clr:
  - clears both sticky flags
  - if err_clr coincides with a new error event, the set wins
  - does not affect state or counters
- Reset mid-WAIT abandons the token; a token returning after reset during WARMUP is silently discarded.
- busy is the registered decode of the ISSUE, WAIT and ACK states.

Test Plan:
- Grace: defaults (GRACE_PERIOD=16), host_ap_start=1 from reset release → pp_start_valid=0 for the first 16 cycles; first pulse in cycle 17; exactly one pulse.
- Round trip: bench loopback delay 16 (token returned 16 cycles after pp_start_valid) → host_ap_ready one cycle after the returned token; txn_count=1; no errors.
- Back-to-back: host_ap_start held high for 3 transactions → 3 single pp_start_valid pulses spaced 19 cycles apart, 3 host_ap_ready pulses, txn_count=3.
- Timeout: TIMEOUT=20, no return token → timeout_err=1 after 20 WAIT cycles; token injected at cycle 30 → host_ap_ready pulses; timeout_err stays 1 until err_clr.
- Stray: pp_ready_valid pulse in IDLE → stray_err=1, no host_ap_ready, txn_count unchanged; same pulse during WARMUP → no error.
- Async reset: assert reset mid-WAIT → outputs 0 immediately without a clock edge; after release, grace period restarts and a late token is ignored.
